pingpong_frame_buffer: RTL and testbench

Parametrised double-buffered (ping-pong) frame buffer between a column/note data generator and the VGA draw logic. A producer fills the back bank through a valid/ready write port while a consumer drains the front bank in order. Banks swap automatically once the back bank is full and the front bank is free. Generalises the fixed 32x8 two-RAM scheme with configurable width and depth, explicit handshakes, loop (repeat) mode, flush, and underrun reporting.

---
 rtl/pingpong_frame_buffer.sv | 130 +++++++++++++
 tb/tb_pingpong_frame_buffer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_frame_buffer.sv
// Double-buffered frame store: the producer fills the back bank while the consumer drains
// the front bank; the banks exchange roles once the back bank is full and the front is free.
module pingpong_frame_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              loop,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              swap,
    output logic              underrun,
    output logic              front_sel
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];

    logic              front_sel_q, front_sel_d;
    logic              front_loaded_q, front_loaded_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_last_q, swap_q, underrun_q;

    logic              back_full, wr_ready_w, rd_ready_w;
    logic              wr_fire, rd_fire, rd_at_last, swap_go;
    logic [ADDR_W-1:0] wr_idx, rd_idx;
    logic [DATA_W-1:0] rd_word;

    assign back_full  = (wr_cnt_q == FULL_CNT);
    assign wr_ready_w = !back_full;
    assign rd_ready_w = front_loaded_q && (rd_ptr_q != FULL_CNT);
    assign wr_idx     = wr_cnt_q[ADDR_W-1:0];
    assign rd_idx     = rd_ptr_q[ADDR_W-1:0];
    assign rd_at_last = (rd_idx == LAST_IDX);

    // flush outranks every data movement in the same cycle
    assign wr_fire = wr_valid && wr_ready_w && !flush;
    assign rd_fire = rd_en && rd_ready_w && !flush;
    assign swap_go = back_full && !flush &&
                     (!front_loaded_q ||
                      (!loop && (rd_ptr_q == FULL_CNT)) ||
                      (loop && rd_fire && rd_at_last));

    // The read always uses the pre-swap front bank, so a swap on a last-index read is seamless
    assign rd_word = front_sel_q ? mem_b[rd_idx] : mem_a[rd_idx];

    always_comb begin
        front_sel_d    = front_sel_q;
        front_loaded_d = front_loaded_q;
        wr_cnt_d       = wr_cnt_q;
        rd_ptr_d       = rd_ptr_q;
        rd_data_d      = rd_data_q;
        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + (ADDR_W + 1)'(1);
        end
        if (rd_fire) begin
            rd_data_d = rd_word;
            rd_ptr_d  = (loop && rd_at_last) ? '0 : rd_ptr_q + (ADDR_W + 1)'(1);
        end
        if (swap_go) begin
            front_sel_d    = !front_sel_q;
            front_loaded_d = 1'b1;
            wr_cnt_d       = '0;
            rd_ptr_d       = '0;
        end
        if (flush) begin
            front_sel_d    = 1'b0;
            front_loaded_d = 1'b0;
            wr_cnt_d       = '0;
            rd_ptr_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire && front_sel_q) begin
            mem_a[wr_idx] <= wr_data;
        end
        if (wr_fire && !front_sel_q) begin
            mem_b[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            front_sel_q    <= 1'b0;
            front_loaded_q <= 1'b0;
            wr_cnt_q       <= '0;
            rd_ptr_q       <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            rd_last_q      <= 1'b0;
            swap_q         <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            front_sel_q    <= front_sel_d;
            front_loaded_q <= front_loaded_d;
            wr_cnt_q       <= wr_cnt_d;
            rd_ptr_q       <= rd_ptr_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_fire;
            rd_last_q      <= rd_fire && rd_at_last;
            swap_q         <= swap_go;
            underrun_q     <= rd_en && !rd_ready_w;
        end
    end

    assign wr_ready  = wr_ready_w;
    assign rd_ready  = rd_ready_w;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign swap      = swap_q;
    assign underrun  = underrun_q;
    assign front_sel = front_sel_q;

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Bench for pingpong_frame_buffer: a frame-level queue model checks the 32x8 instance under
// directed and random traffic; a cycle table checks a 4x16 instance including wrap and flush.
module tb_pingpong_frame_buffer;

    localparam int DP = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, flush, loop, wr_valid, rd_en;
    logic [7:0] wr_data;
    logic       wr_ready, rd_ready, rd_valid, rd_last, swap, underrun, front_sel;
    logic [7:0] rd_data;

    logic        s_flush, s_loop, s_wr_valid, s_rd_en;
    logic [15:0] s_wr_data;
    logic        s_wr_ready, s_rd_ready, s_rd_valid, s_rd_last, s_swap, s_underrun, s_front_sel;
    logic [15:0] s_rd_data;

    pingpong_frame_buffer #(.DATA_W(8), .DEPTH(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .loop(loop),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_last(rd_last), .swap(swap), .underrun(underrun), .front_sel(front_sel)
    );

    pingpong_frame_buffer #(.DATA_W(16), .DEPTH(4), .ADDR_W(2)) dut_s (
        .clk(clk), .reset(reset), .flush(s_flush), .loop(s_loop),
        .wr_valid(s_wr_valid), .wr_data(s_wr_data), .wr_ready(s_wr_ready),
        .rd_en(s_rd_en), .rd_ready(s_rd_ready), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .rd_last(s_rd_last), .swap(s_swap), .underrun(s_underrun), .front_sel(s_front_sel)
    );

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    string ph = "reset";

    // Frame-level reference: back frame as a queue, front frame as a snapshot array
    logic [7:0] backq[$];
    logic [7:0] frontf [DP];
    bit         m_loaded, m_fsel, m_valid, m_last, m_swap, m_under;
    int         m_pos;
    logic [7:0] m_data;

    function automatic void model_reset();
        backq.delete();
        m_loaded = 0; m_fsel = 0; m_pos = 0;
        m_valid = 0; m_last = 0; m_swap = 0; m_under = 0; m_data = 8'h00;
    endfunction

    function automatic void model_step(bit fl, bit lp, bit wv, logic [7:0] wd, bit re);
        bit full, rdy, acc_rd, done;
        int p0;
        full = (backq.size() == DP);
        rdy = m_loaded && (m_pos < DP);
        m_under = re && !rdy;
        m_valid = 0; m_last = 0; m_swap = 0;
        if (fl) begin
            backq.delete();
            m_loaded = 0; m_pos = 0; m_fsel = 0;
        end else begin
            acc_rd = re && rdy;
            p0 = m_pos;
            if (acc_rd) begin
                m_data = frontf[p0];
                m_valid = 1;
                m_last = (p0 == DP - 1);
                m_pos = (lp && p0 == DP - 1) ? 0 : p0 + 1;
            end
            done = !m_loaded || (!lp && p0 == DP) || (lp && acc_rd && p0 == DP - 1);
            if (full && done) begin
                for (int i = 0; i < DP; i++) frontf[i] = backq[i];
                backq.delete();
                m_pos = 0; m_loaded = 1; m_fsel = !m_fsel; m_swap = 1;
            end else if (wv && !full) begin
                backq.push_back(wd);
            end
        end
    endfunction

    task automatic check_main();
        logic [14:0] got, exp;
        got = {wr_ready, rd_ready, rd_valid, rd_last, swap, underrun, front_sel, rd_data};
        exp = {(backq.size() != DP), (m_loaded && m_pos < DP), m_valid, m_last,
               m_swap, m_under, m_fsel, m_data};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d {wrr,rdr,vld,last,swap,under,fsel,data} got=%h exp=%h",
                     ph, cyc_n, got, exp);
        end
    endtask

    task automatic cyc(input bit fl, input bit lp, input bit wv, input logic [7:0] wd, input bit re);
        flush = fl; loop = lp; wr_valid = wv; wr_data = wd; rd_en = re;
        model_step(fl, lp, wv, wd, re);
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        check_main();
    endtask

    typedef struct {
        bit fl, lp, wv;
        logic [15:0] wd;
        bit re;
        bit e_wrr, e_rdr, e_vld;
        logic [15:0] e_data;
        bit e_last, e_swap, e_under, e_fs;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit fl, lp, wv, input logic [15:0] wd, input bit re,
                       input bit e_wrr, e_rdr, e_vld, input logic [15:0] e_data,
                       input bit e_last, e_swap, e_under, e_fs);
        vec_t v;
        v.fl = fl; v.lp = lp; v.wv = wv; v.wd = wd; v.re = re;
        v.e_wrr = e_wrr; v.e_rdr = e_rdr; v.e_vld = e_vld; v.e_data = e_data;
        v.e_last = e_last; v.e_swap = e_swap; v.e_under = e_under; v.e_fs = e_fs;
        tbl.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [22:0] sg, se;
        bit lp_r;

        //          fl lp wv wd       re | wrr rdr vld data     last swp und fs
        add(0, 1, 1, 16'hA001, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 0);
        add(0, 1, 1, 16'hA002, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 0);
        add(0, 1, 1, 16'hA003, 0,  1, 0, 0, 16'h0000, 0, 0, 0, 0);
        add(0, 1, 1, 16'hA004, 0,  0, 0, 0, 16'h0000, 0, 0, 0, 0);
        add(0, 1, 0, 16'h0000, 0,  1, 1, 0, 16'h0000, 0, 1, 0, 1);
        add(0, 1, 0, 16'h0000, 1,  1, 1, 1, 16'hA001, 0, 0, 0, 1);
        add(0, 1, 1, 16'hB001, 1,  1, 1, 1, 16'hA002, 0, 0, 0, 1);
        add(0, 1, 1, 16'hB002, 1,  1, 1, 1, 16'hA003, 0, 0, 0, 1);
        add(0, 1, 1, 16'hB003, 1,  1, 1, 1, 16'hA004, 1, 0, 0, 1);
        add(0, 1, 1, 16'hB004, 1,  0, 1, 1, 16'hA001, 0, 0, 0, 1);
        add(0, 1, 0, 16'h0000, 1,  0, 1, 1, 16'hA002, 0, 0, 0, 1);
        add(0, 1, 0, 16'h0000, 1,  0, 1, 1, 16'hA003, 0, 0, 0, 1);
        add(0, 1, 0, 16'h0000, 1,  1, 1, 1, 16'hA004, 1, 1, 0, 0);
        add(0, 1, 0, 16'h0000, 1,  1, 1, 1, 16'hB001, 0, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 1,  1, 1, 1, 16'hB002, 0, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 1,  1, 1, 1, 16'hB003, 0, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 1,  1, 0, 1, 16'hB004, 1, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 1,  1, 0, 0, 16'hB004, 0, 0, 1, 0);
        add(0, 0, 0, 16'h0000, 0,  1, 0, 0, 16'hB004, 0, 0, 0, 0);
        add(0, 0, 1, 16'hC001, 0,  1, 0, 0, 16'hB004, 0, 0, 0, 0);
        add(1, 0, 1, 16'hC002, 0,  1, 0, 0, 16'hB004, 0, 0, 0, 0);
        add(0, 0, 1, 16'hD001, 0,  1, 0, 0, 16'hB004, 0, 0, 0, 0);
        add(0, 0, 1, 16'hD002, 0,  1, 0, 0, 16'hB004, 0, 0, 0, 0);
        add(0, 0, 1, 16'hD003, 0,  1, 0, 0, 16'hB004, 0, 0, 0, 0);
        add(0, 0, 1, 16'hD004, 0,  0, 0, 0, 16'hB004, 0, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 0,  1, 1, 0, 16'hB004, 0, 1, 0, 1);
        add(0, 0, 0, 16'h0000, 1,  1, 1, 1, 16'hD001, 0, 0, 0, 1);

        reset = 1; flush = 0; loop = 0; wr_valid = 0; wr_data = 0; rd_en = 0;
        s_flush = 0; s_loop = 0; s_wr_valid = 0; s_wr_data = 0; s_rd_en = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        check_main();
        sg = {s_wr_ready, s_rd_ready, s_rd_valid, s_rd_last, s_swap, s_underrun, s_front_sel, s_rd_data};
        se = {1'b1, 22'd0};
        checks++;
        if (sg !== se) begin
            failures++;
            $display("FAIL small_reset got=%h exp=%h", sg, se);
        end

        ph = "small_table";
        for (int i = 0; i < tbl.size(); i++) begin
            s_flush = tbl[i].fl; s_loop = tbl[i].lp; s_wr_valid = tbl[i].wv;
            s_wr_data = tbl[i].wd; s_rd_en = tbl[i].re;
            @(posedge clk);
            @(negedge clk);
            sg = {s_wr_ready, s_rd_ready, s_rd_valid, s_rd_last, s_swap, s_underrun, s_front_sel, s_rd_data};
            se = {tbl[i].e_wrr, tbl[i].e_rdr, tbl[i].e_vld, tbl[i].e_last, tbl[i].e_swap,
                  tbl[i].e_under, tbl[i].e_fs, tbl[i].e_data};
            checks++;
            if (sg !== se) begin
                failures++;
                $display("FAIL small_row%0d {wrr,rdr,vld,last,swap,under,fsel,data} got=%h exp=%h",
                         i, sg, se);
            end
        end
        s_wr_valid = 0; s_rd_en = 0; s_flush = 0;

        ph = "fill_read";
        for (int i = 0; i < DP; i++) cyc(0, 0, 1, 8'(i), 0);
        cyc(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < DP; i++) cyc(0, 0, 0, 8'h00, 1);
        repeat (2) cyc(0, 0, 0, 8'h00, 0);

        ph = "loop_swap";
        for (int i = 0; i < DP; i++) cyc(0, 0, 1, 8'($urandom), 0);
        cyc(0, 0, 0, 8'h00, 0);
        for (int k = 0; k < 110; k++) cyc(0, 1, (k >= 40 && k < 72), 8'($urandom), 1);

        ph = "underrun";
        for (int k = 0; k < 40; k++) cyc(0, 0, 0, 8'h00, 1);
        for (int k = 0; k < 40; k++) cyc(0, 0, 1, 8'($urandom), 1);
        for (int k = 0; k < 10; k++) cyc(0, 0, 0, 8'h00, 1);

        ph = "random";
        lp_r = 0;
        for (int k = 0; k < 800; k++) begin
            if (k % 60 == 0) lp_r = ($urandom % 2) == 1;
            cyc(($urandom % 100) == 0, lp_r, ($urandom % 2) == 1, 8'($urandom), ($urandom % 4) != 0);
        end

        ph = "flush";
        cyc(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < DP; i++) cyc(0, 0, 1, 8'($urandom), 0);
        cyc(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 8'($urandom), 1);
        cyc(1, 0, 1, 8'($urandom), 1);
        for (int i = 0; i < DP; i++) cyc(0, 0, 1, 8'(8'h80 + i), 1);
        for (int i = 0; i < DP + 3; i++) cyc(0, 0, 0, 8'h00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
